// File: rtl/mesi_isc_tb_mem_pkg.sv
// Shared encodings for the mbus main-memory responder: command codes and FSM states.
package mesi_isc_tb_mem_pkg;

  // mbus command encodings; codes 5..7 are illegal
  localparam logic [2:0] MBUS_CMD_NOP      = 3'd0;
  localparam logic [2:0] MBUS_CMD_WR       = 3'd1;
  localparam logic [2:0] MBUS_CMD_RD       = 3'd2;
  localparam logic [2:0] MBUS_CMD_WR_BROAD = 3'd3;
  localparam logic [2:0] MBUS_CMD_RD_BROAD = 3'd4;

  // responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/mesi_isc_tb_mem_array.sv
// Word-wide register array with async clear, one write port and a registered read port.
// The read register holds its value until the next read enable.
module mesi_isc_tb_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_reg;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    // each word clears on reset and loads when the write port selects it
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mem_reg[gi] <= '0;
      end else if (wr_en && (wr_addr == DEPTH_LOG2'(gi))) begin
        mem_reg[gi] <= wr_data;
      end
    end
  end

  // registered read: output updates only on a read, otherwise holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem_reg[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/mesi_isc_tb_mem.sv
// Main-memory responder at the far end of the mbus: one command at a time, fixed
// latency, one-cycle ack, sticky protocol-error flag and saturating counters.
module mesi_isc_tb_mem
  import mesi_isc_tb_mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MBUS_CMD_WIDTH = 3,
  parameter int MEM_DEPTH_LOG2 = 4,
  parameter int LATENCY        = 2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_i,
  input  logic [ADDR_WIDTH-1:0]     mbus_addr_i,
  input  logic [DATA_WIDTH-1:0]     mbus_data_i,
  output logic                      mbus_ack_o,
  output logic [DATA_WIDTH-1:0]     mbus_data_o,
  output logic                      err_o,
  output logic [CNT_WIDTH-1:0]      wr_count_o,
  output logic [CNT_WIDTH-1:0]      rd_count_o
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $fatal(1, "mesi_isc_tb_mem: LATENCY must be in 1..15");
  end

  localparam logic [MBUS_CMD_WIDTH-1:0] CMD_NOP      = MBUS_CMD_WIDTH'(MBUS_CMD_NOP);
  localparam logic [MBUS_CMD_WIDTH-1:0] CMD_WR       = MBUS_CMD_WIDTH'(MBUS_CMD_WR);
  localparam logic [MBUS_CMD_WIDTH-1:0] CMD_RD       = MBUS_CMD_WIDTH'(MBUS_CMD_RD);
  localparam logic [MBUS_CMD_WIDTH-1:0] CMD_WR_BROAD = MBUS_CMD_WIDTH'(MBUS_CMD_WR_BROAD);
  localparam logic [MBUS_CMD_WIDTH-1:0] CMD_RD_BROAD = MBUS_CMD_WIDTH'(MBUS_CMD_RD_BROAD);

  state_t                      state_reg, state_next;
  logic [3:0]                  cnt_reg, cnt_next;
  logic [MBUS_CMD_WIDTH-1:0]   cmd_reg;
  logic [ADDR_WIDTH-1:0]       addr_reg;
  logic [DATA_WIDTH-1:0]       data_reg;
  logic                        err_reg;
  logic [CNT_WIDTH-1:0]        wr_count_reg;
  logic [CNT_WIDTH-1:0]        rd_count_reg;

  logic                        latch_en;
  logic                        enter_ack;
  logic                        in_idle;
  logic                        mismatch;
  logic [MBUS_CMD_WIDTH-1:0]   cmd_op;
  logic [MEM_DEPTH_LOG2-1:0]   idx_op;
  logic [DATA_WIDTH-1:0]       data_op;
  logic                        op_wr, op_rd, op_ill;

  // next-state logic; enter_ack marks the edge on which the memory action happens
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    latch_en   = 1'b0;
    enter_ack  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mbus_cmd_i != CMD_NOP) begin
          latch_en = 1'b1;
          if (LATENCY == 1) begin
            state_next = ACK;
            enter_ack  = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          state_next = ACK;
          enter_ack  = 1'b1;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // with LATENCY=1 the action happens in the same edge as the latch, so use live inputs
  assign in_idle = (state_reg == IDLE);
  assign cmd_op  = in_idle ? mbus_cmd_i : cmd_reg;
  assign idx_op  = in_idle ? mbus_addr_i[MEM_DEPTH_LOG2-1:0] : addr_reg[MEM_DEPTH_LOG2-1:0];
  assign data_op = in_idle ? mbus_data_i : data_reg;

  assign op_wr  = (cmd_op == CMD_WR) || (cmd_op == CMD_WR_BROAD);
  assign op_rd  = (cmd_op == CMD_RD) || (cmd_op == CMD_RD_BROAD);
  assign op_ill = !op_wr && !op_rd;

  // requester must hold cmd/addr/data stable while a transaction is in flight
  assign mismatch = ((state_reg == WAIT) || (state_reg == ACK)) &&
                    ((mbus_cmd_i != cmd_reg) || (mbus_addr_i != addr_reg) ||
                     (mbus_data_i != data_reg));

  // state, latch, error flag and saturating counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      cmd_reg      <= '0;
      addr_reg     <= '0;
      data_reg     <= '0;
      err_reg      <= 1'b0;
      wr_count_reg <= '0;
      rd_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (latch_en) begin
        cmd_reg  <= mbus_cmd_i;
        addr_reg <= mbus_addr_i;
        data_reg <= mbus_data_i;
      end
      if (mismatch || (enter_ack && op_ill)) begin
        err_reg <= 1'b1;
      end
      if (enter_ack && op_wr && (wr_count_reg != '1)) begin
        wr_count_reg <= wr_count_reg + 1'b1;
      end
      if (enter_ack && op_rd && (rd_count_reg != '1)) begin
        rd_count_reg <= rd_count_reg + 1'b1;
      end
    end
  end

  mesi_isc_tb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (MEM_DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (enter_ack && op_wr),
    .wr_addr (idx_op),
    .wr_data (data_op),
    .rd_en   (enter_ack && op_rd),
    .rd_addr (idx_op),
    .rd_data (mbus_data_o)
  );

  assign mbus_ack_o = (state_reg == ACK);
  assign err_o      = err_reg;
  assign wr_count_o = wr_count_reg;
  assign rd_count_o = rd_count_reg;

endmodule

// File: tb/tb_mesi_isc_tb_mem.sv
// Directed bench: instance A uses LATENCY=2, instance B uses LATENCY=1 with a 3-bit
// counter so saturation is reachable in a few transactions.
module tb_mesi_isc_tb_mem;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [2:0]  cmd_a, cmd_b;
  logic [31:0] addr_a, addr_b, din_a, din_b, dout_a, dout_b;
  logic        ack_a, ack_b, err_a, err_b;
  logic [15:0] wrc_a, rdc_a;
  logic [2:0]  wrc_b, rdc_b;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mesi_isc_tb_mem #(.LATENCY(2), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst_a), .mbus_cmd_i(cmd_a), .mbus_addr_i(addr_a),
    .mbus_data_i(din_a), .mbus_ack_o(ack_a), .mbus_data_o(dout_a),
    .err_o(err_a), .wr_count_o(wrc_a), .rd_count_o(rdc_a)
  );

  mesi_isc_tb_mem #(.LATENCY(1), .CNT_WIDTH(3)) dut_b (
    .clk(clk), .rst(rst_b), .mbus_cmd_i(cmd_b), .mbus_addr_i(addr_b),
    .mbus_data_i(din_b), .mbus_ack_o(ack_b), .mbus_data_o(dout_b),
    .err_o(err_b), .wr_count_o(wrc_b), .rd_count_o(rdc_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
    if (sel) begin cmd_b = c; addr_b = a; din_b = d; end
    else     begin cmd_a = c; addr_a = a; din_a = d; end
  endtask

  // Called at a negedge; holds the command until the edge that samples ack.
  task automatic txn(input bit sel, input string tag, input logic [2:0] c, input logic [31:0] a,
                     input logic [31:0] d, input int exp_lat, input bit chk_rd,
                     input logic [31:0] exp_rd, output int ack_cyc);
    int k;
    logic ack;
    k = 0;
    ack = 1'b0;
    drive(sel, c, a, d);
    while (!ack && k < 20) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      ack = sel ? ack_b : ack_a;
    end
    check({tag, " latency"}, k, exp_lat);
    if (chk_rd) check({tag, " rdata"}, sel ? dout_b : dout_a, exp_rd);
    ack_cyc = cyc;
    @(posedge clk);
    @(negedge clk);
    check({tag, " ack one cycle"}, {31'd0, sel ? ack_b : ack_a}, 32'd0);
    drive(sel, 3'd0, 32'd0, 32'd0);
    $display("txn %s: cmd=%0d addr=0x%0h data=0x%0h latency=%0d", tag, c, a, d, k);
  endtask

  initial begin
    int c1, c2, c3, dummy;
    bit acked;
    rst_a = 1'b1; rst_b = 1'b1;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    drive(1'b1, 3'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    // reset state
    check("reset ack", {31'd0, ack_a}, 32'd0);
    check("reset dout", dout_a, 32'd0);
    check("reset err", {31'd0, err_a}, 32'd0);
    check("reset wrc", wrc_a, 32'd0);
    check("reset rdc", rdc_a, 32'd0);

    // basic write / read
    txn(1'b0, "wr3", 3'd1, 32'h3, 32'hDEADBEEF, 2, 1'b0, 32'd0, dummy);
    check("wr3 wrc", wrc_a, 32'd1);
    check("wr3 err", {31'd0, err_a}, 32'd0);
    check("wr3 dout unchanged", dout_a, 32'd0);
    txn(1'b0, "rd3", 3'd2, 32'h3, 32'd0, 2, 1'b1, 32'hDEADBEEF, dummy);
    check("rd3 rdc", rdc_a, 32'd1);

    // upper address bits ignored; data_o holds across a write
    txn(1'b0, "wr3b", 3'd1, 32'h3, 32'h12345678, 2, 1'b0, 32'd0, dummy);
    check("dout holds after wr", dout_a, 32'hDEADBEEF);
    txn(1'b0, "rd13", 3'd2, 32'h13, 32'd0, 2, 1'b1, 32'h12345678, dummy);

    // broadcast read of an unwritten word
    txn(1'b0, "rdb5", 3'd4, 32'h5, 32'd0, 2, 1'b1, 32'h0, dummy);
    check("rdb5 rdc", rdc_a, 32'd3);

    // illegal command is acked, sets sticky error, no counts
    txn(1'b0, "ill6", 3'd6, 32'h4, 32'h99, 2, 1'b0, 32'd0, dummy);
    check("ill6 err", {31'd0, err_a}, 32'd1);
    check("ill6 wrc", wrc_a, 32'd2);
    check("ill6 rdc", rdc_a, 32'd3);
    @(negedge clk);
    check("ill6 err sticky", {31'd0, err_a}, 32'd1);

    // async reset clears everything
    rst_a = 1'b1;
    #1;
    check("rst2 err", {31'd0, err_a}, 32'd0);
    check("rst2 dout", dout_a, 32'd0);
    check("rst2 wrc", wrc_a, 32'd0);
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);

    // address changes during WAIT: error flagged, write uses latched values
    drive(1'b0, 3'd1, 32'h1, 32'hAAAA5555);
    @(posedge clk);
    @(negedge clk);
    addr_a = 32'h2;
    @(posedge clk);
    @(negedge clk);
    check("viol ack", {31'd0, ack_a}, 32'd1);
    check("viol err", {31'd0, err_a}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    check("viol wrc", wrc_a, 32'd1);
    $display("txn viol: WR addr 1 -> 2 during WAIT");
    txn(1'b0, "viol rd1", 3'd2, 32'h1, 32'd0, 2, 1'b1, 32'hAAAA5555, dummy);
    txn(1'b0, "viol rd2", 3'd2, 32'h2, 32'd0, 2, 1'b1, 32'h0, dummy);

    // reset during WAIT discards the pending write
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    drive(1'b0, 3'd1, 32'h7, 32'h77);
    @(posedge clk);
    @(negedge clk);
    rst_a = 1'b1;
    #1;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    @(negedge clk);
    rst_a = 1'b0;
    acked = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack_a) acked = 1'b1;
    end
    check("rstwait no ack", {31'd0, acked}, 32'd0);
    check("rstwait wrc", wrc_a, 32'd0);
    $display("txn rstwait: WR addr 7 aborted by reset");
    txn(1'b0, "rstwait rd7", 3'd2, 32'h7, 32'd0, 2, 1'b1, 32'h0, dummy);
    check("rstwait rdc", rdc_a, 32'd1);
    check("rstwait err", {31'd0, err_a}, 32'd0);

    // LATENCY=1 back-to-back WR, RD, WR
    txn(1'b1, "b wr4", 3'd1, 32'h4, 32'h11, 1, 1'b0, 32'd0, c1);
    txn(1'b1, "b rd4", 3'd2, 32'h4, 32'd0, 1, 1'b1, 32'h11, c2);
    txn(1'b1, "b wr5", 3'd1, 32'h5, 32'h22, 1, 1'b0, 32'd0, c3);
    check("b spacing 1", c2 - c1, 32'd2);
    check("b spacing 2", c3 - c2, 32'd2);
    check("b wrc", wrc_b, 32'd2);
    check("b rdc", rdc_b, 32'd1);
    check("b err", {31'd0, err_b}, 32'd0);

    // counter saturation at 7 for the 3-bit instance
    for (int i = 0; i < 6; i++) begin
      txn(1'b1, "b sat wr", 3'd3, 32'(8 + i), 32'(i), 1, 1'b0, 32'd0, dummy);
      check("b sat wrc", wrc_b, (3 + i > 7) ? 32'd7 : 32'(3 + i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mesi_isc_tb_mem.md
Name: mesi_isc_tb_mem

Overview:
- Main-memory responder for the MESI testbench main bus (mbus).
- Sits at the far end of the mbus driven by each testbench CPU (cmd/addr/data out, ack in). It accepts one command at a time, performs a word read or write on a small internal memory after a fixed latency, and returns a one-cycle ack with read data.
- Also flags protocol violations and counts completed transactions, so the bench can score CPU-side behaviour.

Parameters:
- ADDR_WIDTH, 32, mbus address width
- DATA_WIDTH, 32, mbus data width
- MBUS_CMD_WIDTH, 3, mbus command width
- MEM_DEPTH_LOG2, 4, log2 of the memory word count (16 words)
- LATENCY, 2, cycles from command sample to ack; legal range 1..15
- CNT_WIDTH, 16, width of the transaction counters

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- mbus_cmd_i  in  MBUS_CMD_WIDTH  command from the CPU: NOP=0, WR=1, RD=2, WR_BROAD=3, RD_BROAD=4; 5..7 illegal
- mbus_addr_i  in  ADDR_WIDTH  word address; only bits [MEM_DEPTH_LOG2-1:0] index memory
- mbus_data_i  in  DATA_WIDTH  write data
- mbus_ack_o  out  1  one-cycle completion pulse
- mbus_data_o  out  DATA_WIDTH  read data, valid while mbus_ack_o is high
- err_o  out  1  sticky error flag
- wr_count_o  out  CNT_WIDTH  completed writes, saturating
- rd_count_o  out  CNT_WIDTH  completed reads, saturating

Behaviour:
- Reset (async, active-high): state IDLE; mbus_ack_o=0; mbus_data_o=0; err_o=0; both counters 0; all memory words 0.
- A pending transaction is discarded on reset: no write, no ack.
- FSM states are IDLE, WAIT and ACK.
- IDLE: at an edge where mbus_cmd_i != NOP, latch cmd, addr and data, then:
  - if LATENCY=1, go to ACK;
  - otherwise load cnt=LATENCY-2 and go to WAIT.
- WAIT:
  - cnt != 0: decrement cnt.
  - cnt == 0: go to ACK.
- Memory action happens on the edge that enters ACK:
  - WR or WR_BROAD: mem[idx] <= latched data; wr_count_o += 1.
  - RD or RD_BROAD: mbus_data_o <= mem[idx]; rd_count_o += 1.
  - Illegal command (5..7): no memory access, no count, err_o <= 1. It is still acked, so the requester does not hang.
- ACK: mbus_ack_o=1 for exactly one cycle, then IDLE unconditionally.
- Timing: a command first sampled at edge N produces ack high between edges N+LATENCY-1 and N+LATENCY. The requester sees ack at edge N+LATENCY.
- Requester rule: hold cmd, addr and data stable from first assertion through the edge that samples ack. Change them only after that edge.
- Back-to-back: the command present in the first IDLE cycle after ACK is a new transaction, even if it equals the previous one. This gives minimum spacing LATENCY+1 cycles per transaction.
- Protocol check: at any edge while the state is WAIT or ACK, mbus_cmd_i, mbus_addr_i or mbus_data_i differing from the latched values sets err_o.
  - The latched transaction still completes with the latched values.
- mbus_data_o keeps its last value after ACK and updates only on reads.
- Counters saturate at all-ones and do not wrap.
- Read-after-write to the same index in the next transaction returns the new data.
- LATENCY outside 1..15 is a fatal elaboration error.

Decomposition:
- Shared defines/package mesi_isc_tb_mem_pkg holds:
  - mbus command encodings (NOP, WR, RD, WR_BROAD, RD_BROAD);
  - FSM state encodings (IDLE=0, WAIT=1, ACK=2).
- One sub-module, mesi_isc_tb_mem_array: 2^MEM_DEPTH_LOG2 x DATA_WIDTH register array with async clear, single write port and registered read port.
- FSM, latch, counters and checker stay in the top level.

Test Plan:
- Reset, then WR addr=0x3 data=0xDEADBEEF with LATENCY=2 → ack high during the cycle N+1..N+2; wr_count_o=1; err_o=0.
- Then RD addr=0x3 → mbus_data_o=0xDEADBEEF with ack; rd_count_o=1.
- RD addr=0x13 after WR addr=0x3 data=0x12345678 → returns 0x12345678 (upper bits ignored).
- RD_BROAD to an unwritten address → 0x00000000.
- Illegal cmd=6 held until ack → ack after LATENCY cycles; err_o=1 and stays high; counters unchanged.
- addr changes from 0x1 to 0x2 while in WAIT → err_o=1; write lands at index 1 with the latched data.
- rst pulsed during WAIT of a WR → no ack; memory unchanged (0); state IDLE; counters 0.
- LATENCY=1, back-to-back WR, RD and WR with no NOP gap → three acks, each 2 cycles apart.
- Preload wr_count_o near saturation with 0xFFFF writes → counter holds 0xFFFF on further writes.
